// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: feeds one external 1-bit full adder LSB first and
// accumulates sum bits and the running carry, pulsing done when the result is committed.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        // New sum bit enters at the MSB so the LSB-first stream lands in place.
        acc_d   = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
        carry_d = fa_cout;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        cnt_d   = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          state_d = StFin;
        end
      end
      StFin: begin
        sum_d  = acc_q;
        cout_d = carry_q;
        if (start) begin
          state_d = StRun;
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StFin);
  assign fa_a   = busy & a_sh_q[0];
  assign fa_b   = busy & b_sh_q[0];
  assign fa_cin = busy & carry_q;
  assign sum    = sum_q;
  assign cout   = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 and WIDTH=1 instances, each driving a NAND full-adder
// model; results go through per-instance scoreboard queues checked by monitors.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  // ---------------- WIDTH=8 instance ----------------
  logic       start8, cin8, fa_a8, fa_b8, fa_cin8, fa_sum8, fa_cout8, busy8, done8, cout8;
  logic [7:0] a8, b8, sum8;

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .fa_a(fa_a8), .fa_b(fa_b8), .fa_cin(fa_cin8), .fa_sum(fa_sum8), .fa_cout(fa_cout8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic start1, cin1, fa_a1, fa_b1, fa_cin1, fa_sum1, fa_cout1, busy1, done1, cout1;
  logic a1, b1, sum1;

  serial_add_ctrl #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .fa_a(fa_a1), .fa_b(fa_b1), .fa_cin(fa_cin1), .fa_sum(fa_sum1), .fa_cout(fa_cout1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  // NAND-only full adders
  logic n1_8, n2_8, n3_8, x_8, n4_8, n5_8, n6_8;
  assign n1_8     = ~(fa_a8 & fa_b8);
  assign n2_8     = ~(fa_a8 & n1_8);
  assign n3_8     = ~(fa_b8 & n1_8);
  assign x_8      = ~(n2_8 & n3_8);
  assign n4_8     = ~(x_8 & fa_cin8);
  assign n5_8     = ~(x_8 & n4_8);
  assign n6_8     = ~(fa_cin8 & n4_8);
  assign fa_sum8  = ~(n5_8 & n6_8);
  assign fa_cout8 = ~(n1_8 & n4_8);

  logic n1_1, n2_1, n3_1, x_1, n4_1, n5_1, n6_1;
  assign n1_1     = ~(fa_a1 & fa_b1);
  assign n2_1     = ~(fa_a1 & n1_1);
  assign n3_1     = ~(fa_b1 & n1_1);
  assign x_1      = ~(n2_1 & n3_1);
  assign n4_1     = ~(x_1 & fa_cin1);
  assign n5_1     = ~(x_1 & n4_1);
  assign n6_1     = ~(fa_cin1 & n4_1);
  assign fa_sum1  = ~(n5_1 & n6_1);
  assign fa_cout1 = ~(n1_1 & n4_1);

  // ---------------- scoreboards ----------------
  logic [8:0] exp8[$];
  logic [1:0] exp1[$];
  bit pend8 = 1'b0;
  bit pend1 = 1'b0;

  // Result is checked at the first negedge after the edge that leaves FIN.
  always @(negedge clk) begin
    if (pend8) begin
      pend8 = 1'b0;
      check("sb8_result_expected", 32'(exp8.size() != 0), 32'd1);
      if (exp8.size() != 0) check("sb8_result", 32'({cout8, sum8}), 32'(exp8.pop_front()));
    end
    if (done8) pend8 = 1'b1;
  end

  always @(negedge clk) begin
    if (pend1) begin
      pend1 = 1'b0;
      check("sb1_result_expected", 32'(exp1.size() != 0), 32'd1);
      if (exp1.size() != 0) check("sb1_result", 32'({cout1, sum1}), 32'(exp1.pop_front()));
    end
    if (done1) pend1 = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic go8(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    @(negedge clk);
    a8 = av; b8 = bv; cin8 = cv; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
  endtask

  task automatic collect8(output int n, output logic [7:0] sa, output logic [7:0] sb);
    n = 0; sa = '0; sb = '0;
    while (busy8 && n < 20) begin
      if (n < 8) begin
        sa[n[2:0]] = fa_a8;
        sb[n[2:0]] = fa_b8;
      end
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done8(input string name);
    int i = 0;
    while (!done8 && i < 40) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(done8), 32'd1);
  endtask

  task automatic wait_done1(input string name);
    int i = 0;
    while (!done1 && i < 10) begin
      @(negedge clk);
      i++;
    end
    check(name, 32'(done1), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  logic [1:0] tbl1 [8];
  int n;
  int unsigned t1, t2;
  int dones;
  logic [7:0] sa, sb;

  initial begin
    tbl1 = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd2, 2'd3};
    rst_n = 1'b0;
    start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
    start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs8", 32'({busy8, done8, cout8, sum8, fa_a8, fa_b8, fa_cin8}), 32'd0);
    check("reset_outputs1", 32'({busy1, done1, cout1, sum1, fa_a1, fa_b1, fa_cin1}), 32'd0);
    rst_n = 1'b1;

    // FF + 01 + 0
    exp8.push_back(9'h100);
    go8(8'hFF, 8'h01, 1'b0);
    collect8(n, sa, sb);
    check("t1_busy_cycles", 32'(n), 32'd8);
    check("t1_done_in_fin", 32'(done8), 32'd1);
    check("t1_fa_zero_in_fin", 32'({fa_a8, fa_b8, fa_cin8}), 32'd0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done8), 32'd0);

    // A5 + 5A + 1, with the serial bit streams captured
    exp8.push_back(9'h100);
    go8(8'hA5, 8'h5A, 1'b1);
    collect8(n, sa, sb);
    check("t2_busy_cycles", 32'(n), 32'd8);
    check("t2_fa_a_stream", 32'(sa), 32'hA5);
    check("t2_fa_b_stream", 32'(sb), 32'h5A);
    wait_done8("t2_done_seen");
    @(negedge clk);

    // start mid-RUN ignored; prior result held until FIN commits
    exp8.push_back(9'h04B);
    go8(8'h3C, 8'h0F, 1'b0);
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    check("t3_prior_result_held", 32'({cout8, sum8}), 32'h100);
    check("t3_still_busy", 32'(busy8), 32'd1);
    wait_done8("t3_done_seen");
    check("t3_prior_held_in_fin", 32'({cout8, sum8}), 32'h100);
    @(negedge clk);
    check("t3_no_extra_op", 32'({busy8, done8}), 32'd0);
    @(negedge clk);
    check("t3_idle", 32'({busy8, done8}), 32'd0);

    // reset mid-RUN: outputs clear at once, aborted op never completes
    go8(8'h77, 8'h11, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t4_async_clear", 32'({busy8, done8, cout8, sum8, fa_a8, fa_b8, fa_cin8}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) dones++;
    end
    check("t4_no_done_after_abort", 32'(dones), 32'd0);
    exp8.push_back(9'h046);
    go8(8'h12, 8'h34, 1'b0);
    wait_done8("t4_done_seen");
    @(negedge clk);

    // start held through FIN: back-to-back results 9 cycles apart
    exp8.push_back(9'h010);
    @(negedge clk);
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80;
    wait_done8("t5_first_done");
    t1 = cyc;
    exp8.push_back(9'h100);
    @(negedge clk);
    start8 = 1'b0;
    check("t5_restart_busy", 32'({busy8, done8}), 32'h2);
    wait_done8("t5_second_done");
    t2 = cyc;
    check("t5_done_spacing", t2 - t1, 32'd9);
    @(negedge clk);

    // WIDTH=1: 1+1+1 with result two cycles after start
    exp1.push_back(2'b11);
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    check("w1_busy", 32'({busy1, done1}), 32'h2);
    @(negedge clk);
    check("w1_done", 32'({busy1, done1}), 32'h1);
    @(negedge clk);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 8; i++) begin
      exp1.push_back(tbl1[i]);
      @(negedge clk);
      {a1, b1, cin1} = 3'(i);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      wait_done1("w1_exh_done");
      @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb8_drained", 32'(exp8.size()), 32'd0);
    check("sb1_drained", 32'(exp1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
